four_bit_demux_dist: RTL



---
 rtl/four_bit_demux_dist.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/four_bit_demux_dist.sv
// four_bit_demux_dist
//   Registered 1-to-4 distributor. One beat per cycle comes in on a
//   valid/ready input and is steered to one of four output channels (a..d).
//   Each channel has a one-entry holding register with its own valid/ready
//   handshake. The destination is either the explicit `sel` (mode=0) or an
//   internal round-robin pointer (mode=1), so a gathered stream can be fanned
//   back out to four sinks.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mode       0 = explicit select, 1 = round-robin
//   sel        destination channel in mode 0 (0=a, 1=b, 2=c, 3=d)
//   in_valid   input beat present
//   in_data    input beat
//   in_ready   destination channel can take a beat this cycle (combinational)
//   out_valid  per-channel valid, bit0=a .. bit3=d
//   out_ready  per-channel sink ready, bit0=a .. bit3=d
//   a, b, c, d channel holding registers
//   rr_ptr     current round-robin pointer
//   beat_cnt   accepted-beat counter, wraps modulo 256
module four_bit_demux_dist #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [1:0]       rr_ptr,
  output logic [7:0]       beat_cnt
);

  // Channel indices, named for readability of the steering logic.
  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

  // Registered state
  logic [WIDTH-1:0] data_a_q, data_b_q, data_c_q, data_d_q;
  logic [WIDTH-1:0] data_a_d, data_b_d, data_c_d, data_d_d;
  logic [3:0]       valid_q, valid_d;
  logic [1:0]       rr_q, rr_d;
  logic [7:0]       cnt_q, cnt_d;

  // Combinational control
  logic [1:0] dst_s;
  logic [3:0] can_load_s;
  logic [3:0] drain_s;
  logic [3:0] load_s;
  logic       ready_s;
  logic       accept_s;

  // Destination selection and per-channel load/drain conditions.
  always_comb begin
    dst_s      = 2'd0;
    can_load_s = 4'b0000;
    drain_s    = 4'b0000;
    ready_s    = 1'b0;
    accept_s   = 1'b0;

    if (mode) begin
      dst_s = rr_q;
    end else begin
      dst_s = sel;
    end

    // A channel can take a beat when empty, or when its current beat leaves
    // on this same edge (full + ready), which gives back-to-back throughput.
    can_load_s = ~valid_q | out_ready;
    drain_s    = valid_q & out_ready;

    // in_ready reflects only the chosen destination: a stalled destination
    // stalls the input, it never redirects to another channel.
    case (dst_s)
      CH_A:    ready_s = can_load_s[0];
      CH_B:    ready_s = can_load_s[1];
      CH_C:    ready_s = can_load_s[2];
      CH_D:    ready_s = can_load_s[3];
      default: ready_s = 1'b0;
    endcase

    accept_s = in_valid & ready_s;
  end

  // One-hot load strobe for the destination channel on accept.
  always_comb begin
    load_s = 4'b0000;
    if (accept_s) begin
      case (dst_s)
        CH_A:    load_s = 4'b0001;
        CH_B:    load_s = 4'b0010;
        CH_C:    load_s = 4'b0100;
        CH_D:    load_s = 4'b1000;
        default: load_s = 4'b0000;
      endcase
    end else begin
      load_s = 4'b0000;
    end
  end

  // Next-state for holding registers: data is only overwritten by a load and
  // is deliberately left untouched on drain.
  always_comb begin
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    data_c_d = data_c_q;
    data_d_d = data_d_q;

    if (load_s[0]) begin
      data_a_d = in_data;
    end else begin
      data_a_d = data_a_q;
    end

    if (load_s[1]) begin
      data_b_d = in_data;
    end else begin
      data_b_d = data_b_q;
    end

    if (load_s[2]) begin
      data_c_d = in_data;
    end else begin
      data_c_d = data_c_q;
    end

    if (load_s[3]) begin
      data_d_d = in_data;
    end else begin
      data_d_d = data_d_q;
    end
  end

  // Next-state for valids, round-robin pointer and beat counter.
  always_comb begin
    valid_d = valid_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;

    // A load wins over a drain on the same channel so the valid stays high.
    valid_d = (valid_q & ~drain_s) | load_s;

    if (accept_s) begin
      cnt_d = cnt_q + 8'd1;
      if (mode) begin
        rr_d = rr_q + 2'd1;
      end else begin
        rr_d = rr_q;
      end
    end else begin
      cnt_d = cnt_q;
      rr_d  = rr_q;
    end
  end

  // State registers with asynchronous clear of all channel contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_a_q <= '0;
      data_b_q <= '0;
      data_c_q <= '0;
      data_d_q <= '0;
      valid_q  <= 4'b0000;
      rr_q     <= 2'd0;
      cnt_q    <= 8'd0;
    end else begin
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      data_c_q <= data_c_d;
      data_d_q <= data_d_d;
      valid_q  <= valid_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Output mapping
  assign in_ready  = ready_s;
  assign out_valid = valid_q;
  assign a         = data_a_q;
  assign b         = data_b_q;
  assign c         = data_c_q;
  assign d         = data_d_q;
  assign rr_ptr    = rr_q;
  assign beat_cnt  = cnt_q;

endmodule
